reel_spin_driver: RTL and testbench

- Bus initiator that animates one slot reel by issuing register writes on the video slot write interface (cs/write/addr/wr_data) of a reel sprite core.
- On a start pulse it runs one spin of the reel strip: accelerate, cruise, decelerate, then creep.
- The scroll offset is written once per frame during vertical blanking, and the reel stops exactly on the requested symbol.
- Sits between the game-control processor and the reel sprite core.

---
 rtl/reel_spin_driver.sv | 179 +++++++++++++++++
 tb/tb_reel_spin_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reel_spin_driver.sv
`default_nettype none
// ============================================================================
// reel_spin_driver: spins one slot reel through slot-bus register writes
// Rev 1.0 - initial release
// ============================================================================
module reel_spin_driver #(
  parameter int          SYM_H         = 64,
  parameter int          NUM_SYM       = 8,
  parameter int          MAX_SPEED     = 16,
  parameter int          MIN_SPEED     = 4,
  parameter int          CRUISE_FRAMES = 60,
  parameter int          TICK_Y        = 480,
  parameter logic [13:0] Y_ADDR        = 14'h2002,
  parameter logic [13:0] CTRL_ADDR     = 14'h2003,
  parameter logic [4:0]  SPIN_CTRL     = 5'b10000,
  parameter logic [4:0]  STOP_CTRL     = 5'b00000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [10:0]                x,
  input  logic [10:0]                y,
  input  logic                       start,
  input  logic [$clog2(NUM_SYM)-1:0] target,
  output logic                       cs,
  output logic                       write,
  output logic [13:0]                addr,
  output logic [31:0]                wr_data,
  output logic                       busy,
  output logic                       done,
  output logic [10:0]                offset
);
  localparam int               REEL_H     = SYM_H * NUM_SYM;
  localparam int               SPD_W      = $clog2(MAX_SPEED + 1);
  localparam int               CNT_W      = $clog2(CRUISE_FRAMES + 1);
  localparam logic [11:0]      REEL_H12   = 12'(REEL_H);
  localparam logic [SPD_W-1:0] MAX_SPD    = SPD_W'(MAX_SPEED);
  localparam logic [SPD_W-1:0] MIN_SPD    = SPD_W'(MIN_SPEED);
  localparam logic [CNT_W-1:0] CRUISE_CNT = CNT_W'(CRUISE_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SPIN, S_ACCEL, S_CRUISE, S_DECEL, S_CREEP, S_WR_STOP, S_FINISH
  } state_t;

  state_t           state;
  state_t           creep_entry;
  logic [SPD_W-1:0] speed;
  logic [SPD_W-1:0] spd_next;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [10:0]      tgt_off;
  logic [10:0]      off_next;
  logic [10:0]      move_off;
  logic [11:0]      dist_now;
  logic [11:0]      dist_next;
  logic             tick_prev;
  logic             tick_now;
  logic             tick;
  logic             moving;
  logic             creep_land;

  function automatic logic [10:0] wrap_add(input logic [10:0] a, input logic [SPD_W-1:0] b);
    logic [11:0] s;
    s = {1'b0, a} + 12'(b);
    if (s >= REEL_H12) s = s - REEL_H12;
    return s[10:0];
  endfunction

  // forward distance on the strip from 'from' to 'to'
  function automatic logic [11:0] wrap_dist(input logic [10:0] to, input logic [10:0] from);
    logic [11:0] d;
    d = {1'b0, to} - {1'b0, from};
    if (d[11]) d = d + REEL_H12;
    return d;
  endfunction

  always_comb begin
    tick_now = (x == 11'd0) && (y == 11'(TICK_Y));
    tick     = tick_now && !tick_prev;
    moving   = (state == S_ACCEL) || (state == S_CRUISE) ||
               (state == S_DECEL) || (state == S_CREEP);
    spd_next = speed;
    case (state)
      S_ACCEL:  spd_next = speed + SPD_W'(1);
      S_CRUISE: spd_next = MAX_SPD;
      S_DECEL:  spd_next = speed - SPD_W'(1);
      default:  spd_next = speed;
    endcase
    off_next    = wrap_add(offset, spd_next);
    dist_now    = wrap_dist(tgt_off, offset);
    dist_next   = wrap_dist(tgt_off, off_next);
    creep_land  = (state == S_CREEP) && (dist_now <= 12'(speed));
    move_off    = creep_land ? tgt_off : off_next;
    cnt_next    = frame_cnt + CNT_W'(1);
    creep_entry = (dist_next == 12'd0) ? S_WR_STOP : S_CREEP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      speed     <= '0;
      frame_cnt <= '0;
      tgt_off   <= '0;
      tick_prev <= 1'b0;
      cs        <= 1'b0;
      write     <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      offset    <= '0;
    end else begin
      tick_prev <= tick_now;
      cs        <= 1'b0;
      write     <= 1'b0;
      done      <= 1'b0;
      if (moving && tick) begin
        offset  <= move_off;
        cs      <= 1'b1;
        write   <= 1'b1;
        addr    <= Y_ADDR;
        wr_data <= {21'b0, move_off};
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            tgt_off <= 11'(target * SYM_H);
            speed   <= '0;
            busy    <= 1'b1;
            cs      <= 1'b1;
            write   <= 1'b1;
            addr    <= CTRL_ADDR;
            wr_data <= {27'b0, SPIN_CTRL};
            state   <= S_WR_SPIN;
          end
        end
        S_WR_SPIN: state <= S_ACCEL;
        S_ACCEL: begin
          if (tick) begin
            speed <= spd_next;
            if (spd_next == MAX_SPD) begin
              frame_cnt <= '0;
              state     <= S_CRUISE;
            end
          end
        end
        S_CRUISE: begin
          if (tick) begin
            frame_cnt <= cnt_next;
            if (cnt_next == CRUISE_CNT)
              state <= (MAX_SPD == MIN_SPD) ? creep_entry : S_DECEL;
          end
        end
        S_DECEL: begin
          if (tick) begin
            speed <= spd_next;
            if (spd_next == MIN_SPD) state <= creep_entry;
          end
        end
        S_CREEP: begin
          if (tick && creep_land) state <= S_WR_STOP;
        end
        S_WR_STOP: begin
          cs      <= 1'b1;
          write   <= 1'b1;
          addr    <= CTRL_ADDR;
          wr_data <= {27'b0, STOP_CTRL};
          state   <= S_FINISH;
        end
        S_FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_reel_spin_driver.sv
`default_nettype none
// tb_reel_spin_driver: vector table of spins with a bus-write scoreboard
module tb_reel_spin_driver;
  localparam int          SYM_H         = 64;
  localparam int          REEL_H        = 512;
  localparam int          MAX_SPEED     = 16;
  localparam int          MIN_SPEED     = 4;
  localparam int          CRUISE_FRAMES = 60;
  localparam int          TICK_Y        = 480;
  localparam logic [13:0] Y_ADDR        = 14'h2002;
  localparam logic [13:0] CTRL_ADDR     = 14'h2003;
  localparam int          HOLD          = 4;
  localparam int          GAP           = 4;
  localparam int          TICK_BUDGET   = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [10:0] y;
  logic        start;
  logic [2:0]  target;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [10:0] offset;

  reel_spin_driver dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .start(start), .target(target),
    .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
    .busy(busy), .done(done), .offset(offset)
  );

  always #5 clk = ~clk;

  typedef struct { logic [13:0] a; logic [31:0] d; } wr_t;
  typedef struct { int tgt; bit glitch; int final_off; int n_y; } vec_t;

  wr_t  sb[$];
  vec_t vecs[4];
  int   n_checks  = 0;
  int   fails     = 0;
  int   done_cnt  = 0;
  int   ywr_cnt   = 0;
  int   model_off = 0;

  // every bus write is popped against the scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (cs || write) begin
      n_checks++;
      if (addr == Y_ADDR) ywr_cnt++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write actual addr=%h data=%h required no write", addr, wr_data);
      end else begin
        e = sb.pop_front();
        if (cs !== 1'b1 || write !== 1'b1 || busy !== 1'b1 || addr !== e.a || wr_data !== e.d) begin
          fails++;
          $display("FAIL bus_write actual cs=%b write=%b busy=%b addr=%h data=%h required cs=1 write=1 busy=1 addr=%h data=%h",
                   cs, write, busy, addr, wr_data, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d (0x%h) required=%0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void push_w(input logic [13:0] a, input int d);
    wr_t e;
    e.a = a;
    e.d = 32'(d);
    sb.push_back(e);
  endfunction

  // expected trajectory of a whole spin, built from the speed profile
  task automatic build_spin(input int tgt);
    int off;
    int goal;
    off  = model_off;
    goal = tgt * SYM_H;
    push_w(CTRL_ADDR, 32'h10);
    for (int s = 1; s <= MAX_SPEED; s++) begin
      off = (off + s) % REEL_H;
      push_w(Y_ADDR, off);
    end
    for (int f = 0; f < CRUISE_FRAMES; f++) begin
      off = (off + MAX_SPEED) % REEL_H;
      push_w(Y_ADDR, off);
    end
    for (int s = MAX_SPEED - 1; s >= MIN_SPEED; s--) begin
      off = (off + s) % REEL_H;
      push_w(Y_ADDR, off);
    end
    if ((goal - off + REEL_H) % REEL_H != 0) begin
      while ((goal - off + REEL_H) % REEL_H > MIN_SPEED) begin
        off = (off + MIN_SPEED) % REEL_H;
        push_w(Y_ADDR, off);
      end
      off = goal;
      push_w(Y_ADDR, off);
    end
    push_w(CTRL_ADDR, 0);
    model_off = off;
  endtask

  task automatic tick(input int exp_y);
    x = 11'd0;
    y = 11'(TICK_Y);
    @(posedge clk); #1;
    if (exp_y >= 0) begin
      check("tick_write_cs", 32'(cs), 1);
      check("tick_write_addr", 32'(addr), 32'(Y_ADDR));
      check("tick_write_data", wr_data, 32'(exp_y));
    end
    repeat (HOLD - 1) @(posedge clk);
    #1;
    x = 11'd37;
    y = 11'd200;
    repeat (GAP) @(posedge clk);
    #1;
  endtask

  task automatic run_spin(input int tgt, input bit glitch, input int exp_final,
                          input int exp_ny, input bit chk_accel);
    int d0;
    int y0;
    int t;
    int ey;
    int tri_v[4] = '{1, 3, 6, 10};
    d0 = done_cnt;
    y0 = ywr_cnt;
    start  = 1'b1;
    target = 3'(tgt);
    build_spin(tgt);
    @(posedge clk); #1;
    start = 1'b0;
    if (chk_accel) begin
      check("spin_ctrl_cs", 32'(cs), 1);
      check("spin_ctrl_addr", 32'(addr), 32'(CTRL_ADDR));
      check("spin_ctrl_data", wr_data, 32'h10);
      check("spin_busy", 32'(busy), 1);
    end
    @(posedge clk); #1;
    t = 0;
    while (done_cnt == d0 && t < TICK_BUDGET) begin
      if (glitch && t == 30) begin
        start  = 1'b1;
        target = 3'(tgt + 2);
        @(posedge clk); #1;
        start  = 1'b0;
        target = 3'(tgt);
      end
      ey = -1;
      if (chk_accel) begin
        if (t < 4) ey = tri_v[t];
        else if (t == 15) ey = 136;
      end
      tick(ey);
      t++;
    end
    check("spin_completed", 32'(done_cnt != d0), 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 32'(done_cnt - d0), 1);
    check("final_offset", 32'(offset), 32'(exp_final));
    check("y_write_count", 32'(ywr_cnt - y0), 32'(exp_ny));
    check("busy_after_done", 32'(busy), 0);
    check("scoreboard_drained", 32'(sb.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"}, 32'(cs), 0);
    check({tag, "_write"}, 32'(write), 0);
    check({tag, "_addr"}, 32'(addr), 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_offset"}, 32'(offset), 0);
  endtask

  initial begin
    vecs[0] = '{tgt: 5, glitch: 1'b0, final_off: 320, n_y: 122};
    vecs[1] = '{tgt: 5, glitch: 1'b1, final_off: 320, n_y: 170};
    vecs[2] = '{tgt: 7, glitch: 1'b0, final_off: 448, n_y: 202};
    vecs[3] = '{tgt: 0, glitch: 1'b0, final_off: 0,   n_y: 186};

    reset  = 1'b1;
    start  = 1'b0;
    target = 3'd0;
    x      = 11'd37;
    y      = 11'd200;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");

    run_spin(3, 1'b0, 192, 90, 1'b1);

    // abort a spin partway through cruise
    start  = 1'b1;
    target = 3'd2;
    build_spin(2);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    repeat (26) tick(-1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    model_off = 0;
    check_all_zero("abort");
    repeat (5) tick(-1);
    check("abort_idle_offset", 32'(offset), 0);
    check("abort_idle_busy", 32'(busy), 0);

    for (int i = 0; i < 4; i++)
      run_spin(vecs[i].tgt, vecs[i].glitch, vecs[i].final_off, vecs[i].n_y, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, fails);
    $finish;
  end
endmodule
`default_nettype wire
